// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// uart_cmd_parser: decodes <letter><digits><CR|LF> UART commands into a letter + 32-bit value
// Revision: 1.0
// ============================================================================
module uart_cmd_parser #(
    parameter int MAX_DIGITS = 10
) (
    input  logic        osc_clk,
    input  logic        i_Rst_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Cmd_DV,
    output logic [7:0]  o_Cmd,
    output logic [31:0] o_Value,
    output logic        o_Err,
    output logic        o_Busy
);

    localparam int                 c_CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGITS  = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_s1, r_s2, r_s3;
    logic [7:0]         r_byte_d1;
    logic [7:0]         r_byte;
    logic [31:0]        r_acc;
    logic [31:0]        w_acc_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [7:0]         r_letter;
    logic [7:0]         w_letter_nxt;
    logic               w_cmd_dv_nxt;
    logic               w_err_nxt;
    logic [7:0]         w_cmd_nxt;
    logic [31:0]        w_value_nxt;

    logic               w_byte_stb;
    logic               w_is_letter;
    logic               w_is_digit;
    logic               w_is_term;
    logic               w_is_esc;
    logic [35:0]        w_acc_mul;

    // The byte pipeline tracks the DV synchronizer so the byte used at the
    // strobe is the one sampled while DV was seen high.
    assign w_byte_stb  = r_s2 & ~r_s3;
    assign w_is_letter = ((r_byte >= 8'h41) && (r_byte <= 8'h5A)) ||
                         ((r_byte >= 8'h61) && (r_byte <= 8'h7A));
    assign w_is_digit  = (r_byte >= 8'h30) && (r_byte <= 8'h39);
    assign w_is_term   = (r_byte == 8'h0D) || (r_byte == 8'h0A);
    assign w_is_esc    = (r_byte == 8'h1B);
    assign w_acc_mul   = ({4'd0, r_acc} * 36'd10) + {32'd0, r_byte[3:0]};
    assign o_Busy      = (r_state != ST_IDLE);

    always_ff @(posedge osc_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge osc_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_byte_d1 <= 8'h00;
            r_byte    <= 8'h00;
            r_acc     <= 32'h0;
            r_cnt     <= '0;
            r_letter  <= 8'h00;
            o_Cmd_DV  <= 1'b0;
            o_Err     <= 1'b0;
            o_Cmd     <= 8'h00;
            o_Value   <= 32'h0;
        end else begin
            r_s1      <= i_Rx_DV;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_byte_d1 <= i_Rx_Byte;
            r_byte    <= r_byte_d1;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_letter  <= w_letter_nxt;
            o_Cmd_DV  <= w_cmd_dv_nxt;
            o_Err     <= w_err_nxt;
            o_Cmd     <= w_cmd_nxt;
            o_Value   <= w_value_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_letter_nxt = r_letter;
        w_cmd_dv_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        w_cmd_nxt    = o_Cmd;
        w_value_nxt  = o_Value;

        if (w_byte_stb) begin
            if (w_is_esc) begin
                w_state_nxt = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_letter) begin
                            w_letter_nxt = r_byte & 8'hDF;
                            w_acc_nxt    = 32'h0;
                            w_cnt_nxt    = '0;
                            w_state_nxt  = ST_DIGITS;
                        end
                    end
                    ST_DIGITS: begin
                        if (w_is_digit) begin
                            if (r_cnt >= c_MAX_CNT) begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = ST_DISCARD;
                            end else begin
                                w_acc_nxt = w_acc_mul[31:0];
                                w_cnt_nxt = r_cnt + c_CNT_W'(1);
                                if (w_acc_mul[35:32] != 4'd0) begin
                                    w_err_nxt   = 1'b1;
                                    w_state_nxt = ST_DISCARD;
                                end
                            end
                        end else if (w_is_term) begin
                            if (r_cnt != '0) begin
                                w_cmd_nxt    = r_letter;
                                w_value_nxt  = r_acc;
                                w_cmd_dv_nxt = 1'b1;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        if (w_is_term) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_parser: directed + randomized byte streams checked against a command-level model
// Revision: 1.0
// ============================================================================
module tb_uart_cmd_parser;

    localparam int MAX_DIGITS = 10;

    logic        osc_clk = 1'b0;
    logic        i_Rst_n;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic        o_Cmd_DV;
    logic [7:0]  o_Cmd;
    logic [31:0] o_Value;
    logic        o_Err;
    logic        o_Busy;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_dv_seen = 0;
    int n_err_seen = 0;
    int n_both = 0;
    int last_pulse_cyc = -1;

    // Command-level model: mode 0 = waiting for letter, 1 = collecting digits, 2 = skipping to terminator
    int          m_mode = 0;
    logic [7:0]  m_letter = 8'h00;
    longint      m_acc = 0;
    int          m_cnt = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [31:0] m_val = 32'h0;

    uart_cmd_parser #(.MAX_DIGITS(MAX_DIGITS)) dut (
        .osc_clk  (osc_clk),
        .i_Rst_n  (i_Rst_n),
        .i_Rx_DV  (i_Rx_DV),
        .i_Rx_Byte(i_Rx_Byte),
        .o_Cmd_DV (o_Cmd_DV),
        .o_Cmd    (o_Cmd),
        .o_Value  (o_Value),
        .o_Err    (o_Err),
        .o_Busy   (o_Busy)
    );

    always #5 osc_clk = ~osc_clk;

    always @(posedge osc_clk) begin
        cyc = cyc + 1;
        #1;
        if (o_Cmd_DV) begin
            n_dv_seen = n_dv_seen + 1;
            last_pulse_cyc = cyc;
        end
        if (o_Err) begin
            n_err_seen = n_err_seen + 1;
            last_pulse_cyc = cyc;
        end
        if (o_Cmd_DV && o_Err) n_both = n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_cmd  = 8'h00;
        m_val  = 32'h0;
    endtask

    task automatic model_apply(input logic [7:0] b, output bit dv, output bit er);
        bit is_letter, is_digit, is_term;
        is_letter = (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
        is_digit  = (b >= 8'h30 && b <= 8'h39);
        is_term   = (b == 8'h0D) || (b == 8'h0A);
        dv = 0;
        er = 0;
        if (b == 8'h1B) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (is_letter) begin
                m_letter = (b >= 8'h61) ? b - 8'd32 : b;
                m_acc = 0;
                m_cnt = 0;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (is_digit) begin
                if (m_cnt == MAX_DIGITS) begin
                    er = 1;
                    m_mode = 2;
                end else begin
                    m_acc = m_acc * 10 + longint'(b - 8'h30);
                    m_cnt = m_cnt + 1;
                    if (m_acc > 64'h0000_0000_FFFF_FFFF) begin
                        er = 1;
                        m_mode = 2;
                    end
                end
            end else if (is_term) begin
                if (m_cnt >= 1) begin
                    dv = 1;
                    m_cmd = m_letter;
                    m_val = m_acc[31:0];
                end else begin
                    er = 1;
                end
                m_mode = 0;
            end else begin
                er = 1;
                m_mode = 2;
            end
        end else begin
            if (is_term) m_mode = 0;
        end
    endtask

    task automatic check_after_byte(input int dv0, input int er0, input int t0, input bit chk_lat,
                                    input bit dv, input bit er);
        check("cmd_dv_pulses", 32'(n_dv_seen - dv0), 32'(dv));
        check("err_pulses", 32'(n_err_seen - er0), 32'(er));
        check("cmd", {24'd0, o_Cmd}, {24'd0, m_cmd});
        check("value", o_Value, m_val);
        check("busy", {31'd0, o_Busy}, {31'd0, (m_mode != 0)});
        if (chk_lat && (dv || er)) check("latency", 32'(last_pulse_cyc - t0), 32'd2);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        int dv0, er0, t0;
        bit dv, er;
        @(posedge osc_clk);
        #1;
        dv0 = n_dv_seen;
        er0 = n_err_seen;
        t0  = cyc + 1;
        i_Rx_Byte = b;
        i_Rx_DV = 1'b1;
        repeat (hi) @(posedge osc_clk);
        #1;
        i_Rx_DV = 1'b0;
        i_Rx_Byte = 8'($urandom);
        repeat (lo) @(posedge osc_clk);
        #2;
        model_apply(b, dv, er);
        check_after_byte(dv0, er0, t0, 1'b1, dv, er);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], $urandom_range(2, 10), $urandom_range(3, 8));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_dv"}, {31'd0, o_Cmd_DV}, 32'd0);
        check({tag, "_err"}, {31'd0, o_Err}, 32'd0);
        check({tag, "_busy"}, {31'd0, o_Busy}, 32'd0);
        check({tag, "_cmd"}, {24'd0, o_Cmd}, 32'd0);
        check({tag, "_value"}, o_Value, 32'd0);
    endtask

    initial begin
        int dv0, er0;
        bit dv, er;
        logic [7:0] b;
        int kind, nd;

        i_Rst_n = 1'b0;
        i_Rx_DV = 1'b0;
        i_Rx_Byte = 8'h00;
        repeat (3) @(posedge osc_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge osc_clk);
        i_Rst_n = 1'b1;
        repeat (2) @(posedge osc_clk);

        send_str("F7050000\015");
        send_str("g42\012");
        send_str("G\015");
        send_str("F4294967295\015");
        send_str("F4294967296\015");
        send_str("F12x34\015A5\015");
        send_str("F12345678901\015");
        send_str(" \015\012Z0\015");
        send_str("F123\033B7");
        send_byte("9", 40, 5);
        send_str("\015");

        // Asynchronous reset in the middle of a command
        send_str("F12");
        @(posedge osc_clk);
        #3;
        i_Rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge osc_clk);
        #3;
        i_Rst_n = 1'b1;
        send_str("C3\015");

        // Reset released while a DV pulse is already in progress
        send_str("Q88\015");
        @(posedge osc_clk);
        #3;
        i_Rst_n = 1'b0;
        i_Rx_DV = 1'b1;
        i_Rx_Byte = "D";
        model_reset();
        dv0 = n_dv_seen;
        er0 = n_err_seen;
        repeat (2) @(posedge osc_clk);
        #3;
        i_Rst_n = 1'b1;
        repeat (6) @(posedge osc_clk);
        #1;
        i_Rx_DV = 1'b0;
        repeat (5) @(posedge osc_clk);
        #2;
        model_apply("D", dv, er);
        check_after_byte(dv0, er0, 0, 1'b0, dv, er);
        send_str("9\015");

        // Randomized streams: mostly well-formed commands interleaved with noise
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                b = 8'($urandom_range(0, 25)) + (($urandom_range(0, 1) == 1) ? 8'h61 : 8'h41);
                send_byte(b, $urandom_range(2, 10), $urandom_range(3, 8));
                nd = $urandom_range(0, 11);
                for (int d = 0; d < nd; d++) begin
                    b = 8'h30 + 8'($urandom_range(0, 9));
                    send_byte(b, $urandom_range(2, 6), $urandom_range(3, 6));
                end
                send_byte(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A, $urandom_range(2, 6), $urandom_range(3, 6));
            end else if (kind < 8) begin
                send_byte(8'($urandom), $urandom_range(2, 6), $urandom_range(3, 6));
            end else if (kind == 8) begin
                send_byte(8'h1B, $urandom_range(2, 6), $urandom_range(3, 6));
            end else begin
                send_byte(8'h0D, $urandom_range(2, 6), $urandom_range(3, 6));
            end
        end

        check("mutual_exclusion", 32'(n_both), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Consumes the byte stream from the UART receiver and decodes ASCII commands of the form `<letter><decimal digits><CR|LF>`, for example `F7050000\r`. Each accepted command is presented as a command letter and a 32-bit unsigned value, qualified by a one-cycle strobe. The block sits between the UART receiver and the SDR control registers, such as the NCO frequency and gain registers. It also moves the receiver's handshake from the UartClk-derived domain into the `osc_clk` domain.

## Interface
- `MAX_DIGITS`, default 10: maximum number of decimal digits accepted per command.
- `osc_clk`  in  1  system clock; all logic is on the rising edge.
- `i_Rst_n`  in  1  reset, asynchronous, active-low.
- `i_Rx_DV`  in  1  byte-valid from the UART receiver.
  - Generated in the slower UartClk domain.
  - Its high time is at least 2 `osc_clk` periods.
- `i_Rx_Byte`  in  8  received byte; stable whenever `i_Rx_DV` is high.
- `o_Cmd_DV`  out  1  one-cycle strobe; `o_Cmd` and `o_Value` are valid while it is high.
- `o_Cmd`  out  8  command letter, uppercase ASCII `A`–`Z`.
- `o_Value`  out  32  parsed unsigned decimal value.
- `o_Err`  out  1  one-cycle strobe flagging a malformed command.
- `o_Busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Input handshake**
  - `i_Rx_DV` passes through a 2-flop synchronizer (s1, s2), then a third flop s3.
  - `byte_stb = s2 & ~s3`. Exactly one `byte_stb` is produced per `i_Rx_DV` pulse.
  - `i_Rx_Byte` is captured in the cycle where `byte_stb` is high.
- **Byte classes**
  - LETTER: 0x41–0x5A, or 0x61–0x7A folded to uppercase by clearing bit 5.
  - DIGIT: 0x30–0x39.
  - TERM: 0x0D or 0x0A.
  - ESC: 0x1B.
  - OTHER: everything else.
- **ESC in any state** → IDLE. No `o_Err` and no `o_Cmd_DV`.
- **IDLE**
  - LETTER → latch the letter, clear the accumulator and digit count, go to DIGITS.
  - All other bytes are ignored silently, so stray CR/LF and spaces between commands are harmless.
- **DIGITS**
  - DIGIT with count < `MAX_DIGITS`:
    - `acc = acc*10 + (byte-0x30)`, computed 36 bits wide.
    - Count increments.
    - If the 36-bit result exceeds 0xFFFF_FFFF → pulse `o_Err` and go to DISCARD.
  - DIGIT with count == `MAX_DIGITS` → pulse `o_Err` and go to DISCARD.
  - TERM with count ≥ 1 → `o_Cmd <= letter`, `o_Value <= acc[31:0]`, pulse `o_Cmd_DV`, go to IDLE.
  - TERM with count == 0 → pulse `o_Err` and go to IDLE.
  - LETTER or OTHER → pulse `o_Err` and go to DISCARD.
- **DISCARD**
  - Ignore all bytes until TERM, then go to IDLE.
  - No further `o_Err` pulses while in DISCARD.
- `o_Cmd` and `o_Value` hold their last accepted values until the next `o_Cmd_DV`. Error paths never modify them.
- State encoding: IDLE=2'd0, DIGITS=2'd1, DISCARD=2'd2. Unused code → IDLE.

## Timing
- **Reset values**
  - Outputs: `o_Cmd_DV`=0, `o_Err`=0, `o_Busy`=0, `o_Cmd`=8'h00, `o_Value`=32'h0.
  - Internal: state=IDLE, s1=s2=s3=0.
- **Latency**
  - Let edge 0 be the first `osc_clk` edge that samples `i_Rx_DV`=1.
  - `byte_stb` is high during the cycle after edge 1.
  - The state update and any `o_Cmd_DV`/`o_Err` pulse register at edge 2 and stay high for exactly one cycle.
- **Throughput**: one byte per `i_Rx_DV` pulse. Back-to-back bytes at any UART rate are handled; the parser needs only 1 cycle per byte.
- **Mutual exclusion**: `o_Cmd_DV` and `o_Err` are never high in the same cycle.
- **Reset mid-command**
  - Asserting `i_Rst_n` low returns everything to reset values immediately, without waiting for a clock.
  - After release, if `i_Rx_DV` is already high: the synchronizer starts at 0, so the pulse in progress produces a single `byte_stb`. That byte is then parsed from IDLE.

## Test plan
- Send bytes `F`,`7`,`0`,`5`,`0`,`0`,`0`,`0`,0x0D, each as an 8-cycle `i_Rx_DV` pulse → single `o_Cmd_DV` with `o_Cmd`=0x46 and `o_Value`=7050000. `o_Err` never asserts and `o_Busy` returns to 0.
- Send `g`,`4`,`2`,0x0A → `o_Cmd`=0x47, `o_Value`=42. Then send `G`,0x0D → one `o_Err` pulse; `o_Value` stays 42.
- Send `F4294967295\r` → `o_Value`=0xFFFF_FFFF. Then `F4294967296\r` → `o_Err` pulses on the final `6`, no `o_Cmd_DV` follows, and the state is IDLE after `\r`.
- Send `F12x34\r` then `A5\r` → one `o_Err` pulse at `x`, followed by `o_Cmd_DV` with `A`/5. Separately, `F` followed by 11 digits → `o_Err` pulses on the 11th digit.
- Send `F123` then 0x1B then `B7\r` → no error, a single `o_Cmd_DV` with `B`/7. Hold `i_Rx_DV` high for 40 cycles → exactly one byte is processed.
- Assert `i_Rst_n` low asynchronously after `F12` → all outputs are at reset values before the next clock edge. Then send `C3\r` → `o_Cmd_DV` with `C`/3.
